// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG-to-AHB-Lite debug bridge.
// Holds the register widths, the IDCODE value, the TAP state encoding,
// the instruction opcodes, the AHB HTRANS codes and the bus FSM states.
package jtag_pkg;

   localparam int REGISTER_SIZE = 32;
   localparam int IR_SIZE       = 4;
   localparam int STATE_SIZE    = 4;

   localparam logic [REGISTER_SIZE-1:0] IDCODE_VALUE = 32'h1234_5679;

   typedef enum logic [STATE_SIZE-1:0] {
      TEST_LOGIC_RESET = 4'h0,
      RUN_TEST_IDLE    = 4'h1,
      SELECT_DR_SCAN   = 4'h2,
      CAPTURE_DR       = 4'h3,
      SHIFT_DR         = 4'h4,
      EXIT1_DR         = 4'h5,
      PAUSE_DR         = 4'h6,
      EXIT2_DR         = 4'h7,
      UPDATE_DR        = 4'h8,
      SELECT_IR_SCAN   = 4'h9,
      CAPTURE_IR       = 4'hA,
      SHIFT_IR         = 4'hB,
      EXIT1_IR         = 4'hC,
      PAUSE_IR         = 4'hD,
      EXIT2_IR         = 4'hE,
      UPDATE_IR        = 4'hF
   } tapState_t;

   localparam logic [IR_SIZE-1:0] IR_IDCODE    = 4'b0001;
   localparam logic [IR_SIZE-1:0] IR_AHB_ADDR  = 4'b0010;
   localparam logic [IR_SIZE-1:0] IR_AHB_WRITE = 4'b0011;
   localparam logic [IR_SIZE-1:0] IR_AHB_READ  = 4'b0100;
   localparam logic [IR_SIZE-1:0] IR_BYPASS    = 4'b1111;
   localparam logic [IR_SIZE-1:0] IR_CAPTURE   = 4'b0001;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {
      BUS_IDLE = 2'b00,
      BUS_ADDR = 2'b01,
      BUS_DATA = 2'b10
   } busState_t;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine.
// Ports:
//   TCK   - test clock, state advances on the rising edge
//   TRST  - asynchronous active-high reset to TEST_LOGIC_RESET
//   TMS   - mode select steering the state transitions
//   state - current TAP state
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic      TCK,
   input  logic      TRST,
   input  logic      TMS,
   output tapState_t state
);

   tapState_t nextState;

   // The TAP state register; TRST forces the controller into TEST_LOGIC_RESET
   // regardless of the clock.
   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         state <= TEST_LOGIC_RESET;
      end else begin
         state <= nextState;
      end
   end

   // Standard TMS-driven transitions. With TMS held high the controller
   // always reaches TEST_LOGIC_RESET within five edges.
   always_comb begin
      nextState = state;
      case (state)
         TEST_LOGIC_RESET: nextState = TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
         RUN_TEST_IDLE:    nextState = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_DR_SCAN:   nextState = TMS ? SELECT_IR_SCAN   : CAPTURE_DR;
         CAPTURE_DR:       nextState = TMS ? EXIT1_DR         : SHIFT_DR;
         SHIFT_DR:         nextState = TMS ? EXIT1_DR         : SHIFT_DR;
         EXIT1_DR:         nextState = TMS ? UPDATE_DR        : PAUSE_DR;
         PAUSE_DR:         nextState = TMS ? EXIT2_DR         : PAUSE_DR;
         EXIT2_DR:         nextState = TMS ? UPDATE_DR        : SHIFT_DR;
         UPDATE_DR:        nextState = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_IR_SCAN:   nextState = TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
         CAPTURE_IR:       nextState = TMS ? EXIT1_IR         : SHIFT_IR;
         SHIFT_IR:         nextState = TMS ? EXIT1_IR         : SHIFT_IR;
         EXIT1_IR:         nextState = TMS ? UPDATE_IR        : PAUSE_IR;
         PAUSE_IR:         nextState = TMS ? EXIT2_IR         : PAUSE_IR;
         EXIT2_IR:         nextState = TMS ? UPDATE_IR        : SHIFT_IR;
         UPDATE_IR:        nextState = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         default:          nextState = TEST_LOGIC_RESET;
      endcase
   end

endmodule

// File: rtl/jtag.sv
// JTAG TAP that bridges a debug port to a single-master AHB-Lite bus.
// Everything runs on TCK; TRST is an asynchronous active-high reset.
// Ports:
//   TCK, TRST, TMS, TDI, TDO - JTAG pins
//   HREADY, HRESP, HRDATA    - AHB-Lite inputs from the interconnect
//   HWRITE, HTRANS, HADDR,
//   HWDATA                   - AHB-Lite master outputs
// Instructions: IDCODE, AHB_ADDR (set address), AHB_WRITE (load data and
// write), AHB_READ (read, result captured on the next DR scan), BYPASS.
module jtag
   import jtag_pkg::*;
(
   input  logic                     TCK,
   input  logic                     TRST,
   input  logic                     TMS,
   input  logic                     TDI,
   output logic                     TDO,
   input  logic                     HREADY,
   input  logic                     HRESP,
   input  logic [REGISTER_SIZE-1:0] HRDATA,
   output logic                     HWRITE,
   output logic [1:0]               HTRANS,
   output logic [REGISTER_SIZE-1:0] HADDR,
   output logic [REGISTER_SIZE-1:0] HWDATA
);

   tapState_t                tapState;
   logic [IR_SIZE-1:0]       irShift;
   logic [IR_SIZE-1:0]       irReg;
   logic [IR_SIZE-1:0]       activeIr;
   logic [REGISTER_SIZE-1:0] drShift;
   logic [REGISTER_SIZE-1:0] addrReg;
   logic [REGISTER_SIZE-1:0] wdataReg;
   logic [REGISTER_SIZE-1:0] rdataReg;
   logic [REGISTER_SIZE-1:0] hwdataReg;
   busState_t                busState;
   busState_t                busNext;
   logic                     busWrite;
   logic                     startWrite;
   logic                     startRead;

   jtag_tap_fsm tapFsm (
      .TCK   (TCK),
      .TRST  (TRST),
      .TMS   (TMS),
      .state (tapState)
   );

   // Collapse every opcode we do not implement onto BYPASS so the rest of
   // the logic only has to handle five instructions.
   always_comb begin
      activeIr = IR_BYPASS;
      case (irReg)
         IR_IDCODE, IR_AHB_ADDR, IR_AHB_WRITE, IR_AHB_READ: activeIr = irReg;
         default:                                           activeIr = IR_BYPASS;
      endcase
   end

   // TDO shows the bit about to leave the active shift register while
   // shifting and is held low otherwise. BYPASS is a one-bit register, which
   // is simply bit 0 of the shared DR shifter.
   always_comb begin
      TDO = 1'b0;
      if (tapState == SHIFT_IR) begin
         TDO = irShift[IR_SIZE-1];
      end else if (tapState == SHIFT_DR) begin
         TDO = (activeIr == IR_BYPASS) ? drShift[0] : drShift[REGISTER_SIZE-1];
      end
   end

   // Instruction path: capture the fixed pattern, shift MSB-first, and move
   // the shifted value into the active IR on UPDATE_IR. Passing through
   // TEST_LOGIC_RESET always restores IDCODE.
   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         irShift <= '0;
         irReg   <= IR_IDCODE;
      end else begin
         case (tapState)
            TEST_LOGIC_RESET: irReg   <= IR_IDCODE;
            CAPTURE_IR:       irShift <= IR_CAPTURE;
            SHIFT_IR:         irShift <= {irShift[IR_SIZE-2:0], TDI};
            UPDATE_IR:        irReg   <= irShift;
            default:          ;
         endcase
      end
   end

   // Data path: one shared 32-bit shifter serves all data registers. The
   // capture source and update destination depend on the instruction; the
   // READ update deliberately drops the shifted-in bits.
   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         drShift  <= '0;
         addrReg  <= '0;
         wdataReg <= '0;
      end else begin
         case (tapState)
            CAPTURE_DR: begin
               case (activeIr)
                  IR_IDCODE:    drShift <= IDCODE_VALUE;
                  IR_AHB_ADDR:  drShift <= addrReg;
                  IR_AHB_WRITE: drShift <= wdataReg;
                  IR_AHB_READ:  drShift <= rdataReg;
                  default:      drShift <= '0;
               endcase
            end
            SHIFT_DR: drShift <= {drShift[REGISTER_SIZE-2:0], TDI};
            UPDATE_DR: begin
               if (activeIr == IR_AHB_ADDR) begin
                  addrReg <= drShift;
               end
               if (activeIr == IR_AHB_WRITE) begin
                  wdataReg <= drShift;
               end
            end
            default: ;
         endcase
      end
   end

   assign startWrite = (tapState == UPDATE_DR) && (activeIr == IR_AHB_WRITE);
   assign startRead  = (tapState == UPDATE_DR) && (activeIr == IR_AHB_READ);

   // Bus FSM state register.
   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         busState <= BUS_IDLE;
      end else begin
         busState <= busNext;
      end
   end

   // One address cycle, then the data phase stretches until HREADY. A start
   // that arrives while a transfer is still outstanding is dropped.
   always_comb begin
      busNext = busState;
      case (busState)
         BUS_IDLE: if (startWrite || startRead) busNext = BUS_ADDR;
         BUS_ADDR: busNext = BUS_DATA;
         BUS_DATA: if (HREADY) busNext = BUS_IDLE;
         default:  busNext = BUS_IDLE;
      endcase
   end

   // Transfer bookkeeping: latch the direction at start, present write data
   // for the data phase, and keep read data only from an OKAY completion.
   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         busWrite  <= 1'b0;
         hwdataReg <= '0;
         rdataReg  <= '0;
      end else begin
         if ((busState == BUS_IDLE) && (startWrite || startRead)) begin
            busWrite <= startWrite;
         end
         if ((busState == BUS_ADDR) && busWrite) begin
            hwdataReg <= wdataReg;
         end
         if ((busState == BUS_DATA) && HREADY && !busWrite && !HRESP) begin
            rdataReg <= HRDATA;
         end
      end
   end

   assign HTRANS = (busState == BUS_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HWRITE = (busState != BUS_IDLE) && busWrite;
   assign HADDR  = addrReg;
   assign HWDATA = hwdataReg;

endmodule

// File: tb/tb_jtag.sv
// Self-checking bench for the JTAG-to-AHB bridge. A host-level model keeps
// the expected address, write data and read data registers, and every scan
// and bus transfer is checked against it.
module tb_jtag;

   logic        TCK = 1'b0;
   logic        TRST;
   logic        TMS;
   logic        TDI;
   logic        TDO;
   logic        HREADY;
   logic        HRESP;
   logic [31:0] HRDATA;
   logic        HWRITE;
   logic [1:0]  HTRANS;
   logic [31:0] HADDR;
   logic [31:0] HWDATA;

   int          vectors = 0;
   int          miscompares = 0;

   logic [31:0] modelAddr;
   logic [31:0] modelWdata;
   logic [31:0] modelRdata;
   logic [31:0] dout;
   logic [31:0] din;
   logic [3:0]  irOut;
   logic [31:0] rdVal;
   logic        rdResp;

   jtag dut (
      .TCK    (TCK),
      .TRST   (TRST),
      .TMS    (TMS),
      .TDI    (TDI),
      .TDO    (TDO),
      .HREADY (HREADY),
      .HRESP  (HRESP),
      .HRDATA (HRDATA),
      .HWRITE (HWRITE),
      .HTRANS (HTRANS),
      .HADDR  (HADDR),
      .HWDATA (HWDATA)
   );

   // Free-running test clock.
   always #5 TCK = ~TCK;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic tms, input logic tdi);
      @(negedge TCK);
      TMS = tms;
      TDI = tdi;
      @(posedge TCK);
      #1;
   endtask

   // From Run-Test/Idle: full IR scan, ends back in Run-Test/Idle.
   task automatic scanIr(input logic [3:0] ir, output logic [3:0] captured);
      captured = '0;
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      for (int i = 3; i >= 0; i--) begin
         captured[i] = TDO;
         applyStimulus(i == 0, ir[i]);
      end
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
   endtask

   // From Run-Test/Idle: n-bit DR scan MSB-first, ends in Run-Test/Idle
   // right after the UPDATE_DR edge.
   task automatic scanDr(input logic [31:0] data, input int n, output logic [31:0] captured);
      captured = '0;
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      for (int k = 0; k < n; k++) begin
         captured[n-1-k] = TDO;
         applyStimulus(k == n - 1, data[n-1-k]);
      end
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
   endtask

   // Runs a transfer that has just been started (bus in its address cycle)
   // to completion with a given number of wait states, updating the model.
   task automatic runTransfer(input logic isWrite, input int waits, input logic [31:0] rdata, input logic resp);
      checkOutput("addrPhaseHtrans", 32'(HTRANS), 32'h2);
      checkOutput("addrPhaseHwrite", 32'(HWRITE), 32'(isWrite));
      checkOutput("addrPhaseHaddr", HADDR, modelAddr);
      HREADY = 1'b1;
      applyStimulus(1'b0, 1'b0);
      checkOutput("dataPhaseHtrans", 32'(HTRANS), 32'h0);
      if (isWrite) begin
         checkOutput("dataPhaseHwdata", HWDATA, modelWdata);
      end
      for (int w = 0; w < waits; w++) begin
         HREADY = 1'b0;
         HRDATA = $urandom;
         HRESP  = 1'b0;
         applyStimulus(1'b0, 1'b0);
         checkOutput("waitHtrans", 32'(HTRANS), 32'h0);
         checkOutput("waitHwrite", 32'(HWRITE), 32'(isWrite));
      end
      HREADY = 1'b1;
      HRDATA = rdata;
      HRESP  = resp;
      applyStimulus(1'b0, 1'b0);
      if (!isWrite && !resp) begin
         modelRdata = rdata;
      end
      checkOutput("idleHtrans", 32'(HTRANS), 32'h0);
      checkOutput("idleHwrite", 32'(HWRITE), 32'h0);
      HRESP  = 1'b0;
      HRDATA = $urandom;
   endtask

   // Directed sequence with randomized data, checked against the model.
   initial begin
      TRST = 1'b1;
      TMS = 1'b1;
      TDI = 1'b0;
      HREADY = 1'b1;
      HRESP = 1'b0;
      HRDATA = '0;
      modelAddr = '0;
      modelWdata = '0;
      modelRdata = '0;

      #12;
      checkOutput("resetTdo", 32'(TDO), 32'h0);
      checkOutput("resetHtrans", 32'(HTRANS), 32'h0);
      checkOutput("resetHwrite", 32'(HWRITE), 32'h0);
      checkOutput("resetHaddr", HADDR, 32'h0);
      checkOutput("resetHwdata", HWDATA, 32'h0);
      TRST = 1'b0;

      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
      checkOutput("tlrTdo", 32'(TDO), 32'h0);
      applyStimulus(1'b0, 1'b0);

      $display("[TB] IDCODE scan");
      scanDr(32'h0, 32, dout);
      checkOutput("idcode", dout, 32'h1234_5679);
      checkOutput("idcodeHtrans", 32'(HTRANS), 32'h0);

      $display("[TB] address register");
      scanIr(4'b0010, irOut);
      checkOutput("irCapture", 32'(irOut), 32'h1);
      scanDr(32'hFFFF_FFFF, 32, dout);
      checkOutput("addrCapture0", dout, modelAddr);
      modelAddr = 32'hFFFF_FFFF;
      checkOutput("addrHaddr", HADDR, modelAddr);
      checkOutput("addrNoTransfer", 32'(HTRANS), 32'h0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("addrNoTransfer2", 32'(HTRANS), 32'h0);

      $display("[TB] write transfer");
      scanIr(4'b0011, irOut);
      checkOutput("irCapture", 32'(irOut), 32'h1);
      scanDr(32'hFFFF_FFFF, 32, dout);
      checkOutput("wdataCapture0", dout, modelWdata);
      modelWdata = 32'hFFFF_FFFF;
      runTransfer(1'b1, 0, 32'h0, 1'b0);

      $display("[TB] randomized address/write transfers");
      for (int n = 0; n < 4; n++) begin
         scanIr(4'b0010, irOut);
         din = $urandom;
         scanDr(din, 32, dout);
         checkOutput("addrCapture", dout, modelAddr);
         modelAddr = din;
         checkOutput("addrHaddr", HADDR, modelAddr);
         scanIr(4'b0011, irOut);
         din = $urandom;
         scanDr(din, 32, dout);
         checkOutput("wdataCapture", dout, modelWdata);
         modelWdata = din;
         runTransfer(1'b1, int'($urandom_range(0, 3)), $urandom, 1'b0);
      end

      $display("[TB] read transfer");
      scanIr(4'b0100, irOut);
      checkOutput("irCapture", 32'(irOut), 32'h1);
      scanDr($urandom, 32, dout);
      checkOutput("rdataCapture0", dout, modelRdata);
      runTransfer(1'b0, 0, 32'h0000_F00F, 1'b0);
      scanDr($urandom, 32, dout);
      checkOutput("rdataF00F", dout, 32'h0000_F00F);
      runTransfer(1'b0, 0, 32'h0000_F00F, 1'b0);

      $display("[TB] randomized reads with wait states and errors");
      for (int n = 0; n < 6; n++) begin
         rdVal = $urandom;
         rdResp = ($urandom_range(0, 3) == 0);
         scanDr($urandom, 32, dout);
         checkOutput("rdataCapture", dout, modelRdata);
         runTransfer(1'b0, int'($urandom_range(0, 3)), rdVal, rdResp);
      end

      $display("[TB] start ignored while busy");
      scanDr($urandom, 32, dout);
      checkOutput("rdataCapture", dout, modelRdata);
      checkOutput("busyAddrHtrans", 32'(HTRANS), 32'h2);
      HREADY = 1'b0;
      applyStimulus(1'b0, 1'b0);
      scanDr($urandom, 32, dout);
      checkOutput("busyCapture", dout, modelRdata);
      checkOutput("busyHtrans", 32'(HTRANS), 32'h0);
      rdVal = $urandom;
      HRDATA = rdVal;
      HREADY = 1'b1;
      applyStimulus(1'b0, 1'b0);
      modelRdata = rdVal;
      applyStimulus(1'b0, 1'b0);
      checkOutput("ignoredStart", 32'(HTRANS), 32'h0);
      scanDr($urandom, 32, dout);
      checkOutput("busyResult", dout, modelRdata);
      runTransfer(1'b0, 0, 32'h0, 1'b1);

      $display("[TB] bypass and undefined opcode");
      scanIr(4'b1111, irOut);
      din = 32'($urandom_range(0, 255));
      scanDr(din, 8, dout);
      checkOutput("bypass", dout, din >> 1);
      checkOutput("bypassHtrans", 32'(HTRANS), 32'h0);
      scanIr(4'b0110, irOut);
      din = 32'($urandom_range(0, 255));
      scanDr(din, 8, dout);
      checkOutput("undefBypass", dout, din >> 1);
      checkOutput("undefHtrans", 32'(HTRANS), 32'h0);

      $display("[TB] TMS reset from SHIFT_IR");
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      scanDr(32'h0, 32, dout);
      checkOutput("tmsResetIdcode", dout, 32'h1234_5679);

      $display("[TB] TRST mid-transfer");
      scanIr(4'b0011, irOut);
      din = $urandom;
      scanDr(din, 32, dout);
      checkOutput("wdataCapture", dout, modelWdata);
      checkOutput("preResetHtrans", 32'(HTRANS), 32'h2);
      #2;
      TRST = 1'b1;
      #1;
      modelAddr = '0;
      modelWdata = '0;
      modelRdata = '0;
      checkOutput("trstHtrans", 32'(HTRANS), 32'h0);
      checkOutput("trstHwrite", 32'(HWRITE), 32'h0);
      checkOutput("trstHaddr", HADDR, 32'h0);
      checkOutput("trstHwdata", HWDATA, 32'h0);
      checkOutput("trstTdo", 32'(TDO), 32'h0);
      @(negedge TCK);
      TRST = 1'b0;
      applyStimulus(1'b0, 1'b0);
      scanDr(32'h0, 32, dout);
      checkOutput("trstIdcode", dout, 32'h1234_5679);
      scanIr(4'b0100, irOut);
      scanDr($urandom, 32, dout);
      checkOutput("trstRdata", dout, modelRdata);
      runTransfer(1'b0, 1, $urandom, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
